// File: rtl/judge_sequencer_if.sv
// Lane/keyboard inputs and popup/score outputs of the judge sequencer.
// Driver side (movers, keyboard, renderer model) uses master; judge_sequencer uses slave.
interface judge_sequencer_if;
    logic        vs;
    logic [7:0]  keycode;
    logic [3:0]  arrow_valid;
    logic [39:0] arrow_y;
    logic [3:0]  lane_clear;
    logic [3:0]  pop_sprite_id;
    logic [9:0]  pop_x;
    logic [9:0]  pop_y;
    logic        pop_visible;
    logic [15:0] score;
    logic [7:0]  combo;
    logic        busy;

    modport master (
        output vs, keycode, arrow_valid, arrow_y,
        input  lane_clear, pop_sprite_id, pop_x, pop_y, pop_visible, score, combo, busy
    );

    modport slave (
        input  vs, keycode, arrow_valid, arrow_y,
        output lane_clear, pop_sprite_id, pop_x, pop_y, pop_visible, score, combo, busy
    );
endinterface

// File: rtl/judge_sequencer.sv
// Per-frame arrow judgement: scans four lanes round-robin after each vs tick, grades hit/miss,
// owns the popup slot, keeps score/combo. Optional GREAT grading under `JUDGE_GREAT_EN`.
module judge_sequencer #(
    parameter int unsigned WIN_LO      = 16,
    parameter int unsigned WIN_HI      = 56,
    parameter int unsigned HOLD_FRAMES = 30,
    parameter int unsigned HIT_PTS     = 100,
    parameter logic [9:0]  POP_X       = 10'h140,
    parameter logic [9:0]  POP_Y       = 10'hF0
) (
    input logic              Clk,
    input logic              Reset_n,
    judge_sequencer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    localparam logic [9:0] WIN_LO_V = 10'(WIN_LO);
    localparam logic [9:0] WIN_HI_V = 10'(WIN_HI);

    state_t      state_q, state_d;
    logic        vs_q, vs_qq;
    logic [1:0]  k_q, k_d, rr_ptr_q, rr_ptr_d;
    logic [7:0]  key_s_q, key_s_d, key_prev_q, key_prev_d;
    logic [7:0]  hold_cnt_q, hold_cnt_d, combo_q, combo_d;
    logic        tick_pend_q, tick_pend_d, loaded_q, loaded_d;
    logic        pop_visible_q, pop_visible_d;
    logic [3:0]  lane_clear_q, lane_clear_d, pop_id_q, pop_id_d;
    logic [15:0] score_q, score_d;

    logic        tick, valid, hit, miss, great;
    logic [1:0]  lane;
    logic [5:0]  y_base;
    logic [9:0]  lane_y;
    logic [16:0] pts, sum;

    function automatic logic [7:0] lane_key(input logic [1:0] l);
        case (l)
            2'd0:    lane_key = 8'h1A;
            2'd1:    lane_key = 8'h04;
            2'd2:    lane_key = 8'h16;
            default: lane_key = 8'h07;
        endcase
    endfunction

    always_comb begin
        tick   = vs_q & ~vs_qq;
        lane   = rr_ptr_q + k_q;
        y_base = {4'd0, lane} * 6'd10;
        lane_y = bus.arrow_y[y_base +: 10];
        valid  = bus.arrow_valid[lane];
        // key_s != key_prev makes a held key grade only on the frame it was pressed
        hit    = valid && (lane_y > WIN_LO_V) && (lane_y < WIN_HI_V)
                 && (key_s_q == lane_key(lane)) && (key_s_q != key_prev_q);
        miss   = valid && (lane_y >= WIN_HI_V);
`ifdef JUDGE_GREAT_EN
        great  = hit && (lane_y >= 10'd32) && (lane_y <= 10'd40);
`else
        great  = 1'b0;
`endif
        pts    = great ? 17'(2 * HIT_PTS) : 17'(HIT_PTS);
        sum    = {1'b0, score_q} + pts;
    end

    always_comb begin
        state_d       = state_q;
        k_d           = k_q;
        rr_ptr_d      = rr_ptr_q;
        key_s_d       = key_s_q;
        key_prev_d    = key_prev_q;
        hold_cnt_d    = hold_cnt_q;
        combo_d       = combo_q;
        tick_pend_d   = tick_pend_q;
        loaded_d      = loaded_q;
        pop_visible_d = pop_visible_q;
        lane_clear_d  = '0;
        pop_id_d      = pop_id_q;
        score_d       = score_q;
        case (state_q)
            IDLE: begin
                if (tick || tick_pend_q) begin
                    state_d     = SCAN;
                    tick_pend_d = 1'b0;
                    k_d         = '0;
                    key_s_d     = bus.keycode;
                    loaded_d    = 1'b0;
                end
            end
            SCAN: begin
                if (tick) tick_pend_d = 1'b1;
                if (hit || miss) begin
                    lane_clear_d[lane] = 1'b1;
                    if (!loaded_q) begin
                        pop_id_d      = hit ? (great ? 4'hA : 4'h8) : 4'h9;
                        hold_cnt_d    = 8'(HOLD_FRAMES);
                        pop_visible_d = 1'b1;
                        loaded_d      = 1'b1;
                    end
                end
                if (hit) begin
                    score_d = sum[16] ? 16'hFFFF : sum[15:0];
                    combo_d = (combo_q == 8'hFF) ? 8'hFF : combo_q + 8'd1;
                end else if (miss) begin
                    combo_d = '0;
                end
                k_d = k_q + 2'd1;
                if (k_q == 2'd3) state_d = DONE;
            end
            DONE: begin
                if (tick) tick_pend_d = 1'b1;
                key_prev_d = key_s_q;
                rr_ptr_d   = rr_ptr_q + 2'd1;
                if (!loaded_q && hold_cnt_q != '0) begin
                    hold_cnt_d = hold_cnt_q - 8'd1;
                    if (hold_cnt_q == 8'd1) pop_visible_d = 1'b0;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q       <= IDLE;
            vs_q          <= 1'b0;
            vs_qq         <= 1'b0;
            k_q           <= '0;
            rr_ptr_q      <= '0;
            key_s_q       <= '0;
            key_prev_q    <= '0;
            hold_cnt_q    <= '0;
            combo_q       <= '0;
            tick_pend_q   <= 1'b0;
            loaded_q      <= 1'b0;
            pop_visible_q <= 1'b0;
            lane_clear_q  <= '0;
            pop_id_q      <= '0;
            score_q       <= '0;
        end else begin
            state_q       <= state_d;
            vs_q          <= bus.vs;
            vs_qq         <= vs_q;
            k_q           <= k_d;
            rr_ptr_q      <= rr_ptr_d;
            key_s_q       <= key_s_d;
            key_prev_q    <= key_prev_d;
            hold_cnt_q    <= hold_cnt_d;
            combo_q       <= combo_d;
            tick_pend_q   <= tick_pend_d;
            loaded_q      <= loaded_d;
            pop_visible_q <= pop_visible_d;
            lane_clear_q  <= lane_clear_d;
            pop_id_q      <= pop_id_d;
            score_q       <= score_d;
        end
    end

    assign bus.lane_clear    = lane_clear_q;
    assign bus.pop_sprite_id = pop_id_q;
    assign bus.pop_x         = POP_X;
    assign bus.pop_y         = POP_Y;
    assign bus.pop_visible   = pop_visible_q;
    assign bus.score         = score_q;
    assign bus.combo         = combo_q;
    assign bus.busy          = (state_q != IDLE);
endmodule
